// File: rtl/wt_update_ctrl.sv
// wt_update_ctrl: snapshots weights/gradients, computes saturated w - (g >>> lr) one index per cycle,
// then strobes update_wts for NUM_IP cycles so the neuron's serial write counter loads every weight.
module wt_update_ctrl #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int NUM_IP = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NUM_IP*IP_DATA_WIDTH-1:0] wt_cur,
    input  logic [NUM_IP*IP_DATA_WIDTH-1:0] grad,
    input  logic [2:0]                      lr_shift,
    output logic [NUM_IP*IP_DATA_WIDTH-1:0] wt_in,
    output logic                            update_wts,
    output logic                            busy,
    output logic                            done
);
    localparam int W = IP_DATA_WIDTH;
    localparam int IW = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_IP - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NUM_IP*W-1:0] wt_s_q, grad_s_q, wt_q;
    logic [2:0]          lr_q;
    logic signed [W-1:0] w_sel, g_sel, delta, sat;
    logic signed [W:0]   diff;
    logic                last;

    // One extra bit of headroom so overflow shows up as disagreeing top bits
    always_comb begin
        w_sel = wt_s_q[idx_q*W +: W];
        g_sel = grad_s_q[idx_q*W +: W];
        delta = g_sel >>> lr_q;
        diff  = {w_sel[W-1], w_sel} - {delta[W-1], delta};
        sat   = (diff[W] != diff[W-1]) ? (diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                       : diff[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last    = (idx_q == LAST);
        case (state_q)
            IDLE: begin
                idx_d   = '0;
                state_d = start ? COMPUTE : IDLE;
            end
            COMPUTE: begin
                idx_d   = last ? '0 : idx_q + 1'b1;
                state_d = last ? WRITE : COMPUTE;
            end
            WRITE: begin
                idx_d   = last ? '0 : idx_q + 1'b1;
                state_d = last ? DONE : WRITE;
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wt_q     <= '0;
            wt_s_q   <= '0;
            grad_s_q <= '0;
            lr_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && start) begin
                wt_s_q   <= wt_cur;
                grad_s_q <= grad;
                lr_q     <= lr_shift;
            end
            if (state_q == COMPUTE) wt_q[idx_q*W +: W] <= sat;
        end
    end

    assign wt_in      = wt_q;
    assign update_wts = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
endmodule

// File: doc/wt_update_ctrl.md
WT_UPDATE_CTRL -- requirements
Module: wt_update_ctrl

Interface
REQ-001 Parameter IP_DATA_WIDTH, default 8: signed width of each weight and gradient word.
REQ-002 Parameter NUM_IP, default 8: number of weights per neuron, which is also the length of the update burst.
REQ-003 clk  input  1: single clock; all logic is posedge clk.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 start  input  1: request one weight-update pass; sampled only in IDLE.
REQ-006 wt_cur  input  signed [IP_DATA_WIDTH-1:0] x NUM_IP: current neuron weights.
REQ-007 grad  input  signed [IP_DATA_WIDTH-1:0] x NUM_IP: per-weight gradient.
REQ-008 lr_shift  input  3: learning rate expressed as a right-shift amount (0..7).
REQ-009 wt_in  output  signed [IP_DATA_WIDTH-1:0] x NUM_IP: updated weights; connects to the neuron's wt_in.
REQ-010 update_wts  output  1: write strobe; connects to the neuron's update_wts.
REQ-011 busy  output  1: a pass is in progress.
REQ-012 done  output  1: one-cycle pulse marking the end of a pass.

Function
REQ-013 The FSM SHALL have four states: IDLE, COMPUTE, WRITE, DONE.
  - IDLE->COMPUTE when start=1.
  - COMPUTE->WRITE after NUM_IP cycles.
  - WRITE->DONE after NUM_IP cycles.
  - DONE->IDLE unconditionally.
REQ-014 On the edge where start is accepted (E0), the block SHALL snapshot wt_cur, grad and lr_shift into internal registers; input changes after E0 SHALL NOT affect the pass.
REQ-015 COMPUTE SHALL process one index per cycle, idx 0..NUM_IP-1 in order: delta = grad[idx] >>> lr_shift (arithmetic shift), new = wt_cur[idx] - delta.
REQ-016 The subtraction SHALL be evaluated at IP_DATA_WIDTH+1 bits and saturated to [-2^(IP_DATA_WIDTH-1), 2^(IP_DATA_WIDTH-1)-1], i.e. [-128, 127] at default width, before it is stored into wt_in[idx].
REQ-017 wt_in SHALL be fully updated before WRITE begins, and SHALL hold stable through WRITE, DONE and IDLE until the next COMPUTE overwrites it.
REQ-018 update_wts SHALL be 1 for exactly NUM_IP consecutive cycles (the WRITE state) and 0 in every other state, matching the receiver's sequential write counter that advances once per strobe cycle.
REQ-019 Cycle timing, counting cycles after E0 at default NUM_IP=8:
  - cycles 1..8: COMPUTE;
  - cycles 9..16: update_wts=1;
  - cycle 17: done=1;
  - cycle 18: IDLE.
REQ-020 busy SHALL be 1 in COMPUTE, WRITE and DONE, and 0 in IDLE.
REQ-021 start asserted while busy=1 SHALL be ignored, neither queued nor restarting the pass.
REQ-022 start held high continuously SHALL begin a new pass on the first IDLE cycle after DONE, i.e. back-to-back passes with a period of 2*NUM_IP+2 cycles.
REQ-023 The internal index counter SHALL be $clog2(NUM_IP) bits wide, SHALL wrap to 0 at each COMPUTE->WRITE and WRITE->DONE transition, and SHALL be 0 on entry to every state.
REQ-024 lr_shift=0 SHALL apply the full gradient.
REQ-025 lr_shift=7 at 8-bit width SHALL give delta in {-1, 0}.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the index, wt_in (all entries 0), update_wts, busy and done, regardless of the current state.
REQ-027 If rst is asserted mid-WRITE, update_wts SHALL be 0 in the cycle following the reset edge and no further strobes SHALL be issued.
REQ-028 rst SHALL take priority over start in the same cycle.

Verification
REQ-029 Basic pass: wt_cur all 10, grad all 8, lr_shift=2, start pulse -> wt_in all 8; update_wts high on cycles 9..16; done on cycle 17.
REQ-030 Saturation: wt_cur[0]=120 with grad[0]=-64, and wt_cur[1]=-120 with grad[1]=64, lr_shift=0 -> wt_in[0]=127 and wt_in[1]=-128.
REQ-031 Snapshot and ignore: change wt_cur and grad on cycle 3, pulse start on cycle 5 -> results use the E0 values; exactly 8 strobes and one done pulse.
REQ-032 Reset mid-operation: rst on cycle 12 -> update_wts=0, busy=0 and wt_in all 0 from cycle 13; no done pulse.
REQ-033 Back-to-back: start held high for 40 cycles -> two complete passes with done on cycles 17 and 35.
REQ-034 Integration: connect to a neuron instance, run a pass with grad all 0 -> the neuron's weight memory equals wt_cur for all 8 entries.
